// File: rtl/skid_fifo_if.sv
// Ready/valid handshake bundle for skid_fifo: upstream beat in, downstream beat out.
// master = the environment around the buffer, slave = the buffer itself.
interface skid_fifo_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] data_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out
    );
endinterface

// File: rtl/skid_fifo.sv
// DEPTH-entry elastic ready/valid buffer with occupancy, almost-full and single-cycle flush.
// Define SKID_FIFO_BYPASS_EN for zero-latency fall-through when the buffer is empty.
module skid_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    skid_fifo_if.slave                   bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         almost_full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty, full;
    logic push, pop;
    logic wr_en, rd_en;

    // Output view: ready_out comes from registered occupancy only, so it never
    // depends on ready_in and a full buffer cannot take a beat in the cycle it pops.
    always_comb begin
        empty         = (count_q == '0);
        full          = (count_q == FULL_CNT);
        bus.ready_out = !full;
`ifdef SKID_FIFO_BYPASS_EN
        bus.valid_out = empty ? (bus.valid_in && !flush_i) : 1'b1;
        bus.data_out  = empty ? bus.data_in : mem_q[rd_ptr_q];
`else
        bus.valid_out = !empty;
        bus.data_out  = mem_q[rd_ptr_q];
`endif
        count_o       = count_q;
        almost_full_o = (count_q >= AFULL_CNT);
    end

    // A bypassed beat (empty, taken downstream the same cycle) never touches storage.
    always_comb begin
        push  = bus.valid_in  && bus.ready_out && !flush_i;
        pop   = bus.valid_out && bus.ready_in  && !flush_i;
        rd_en = pop && !empty;
        wr_en = push && !(pop && empty);
    end

    // NOTE: every variable assigned in a combinational block gets a default up
    // front so no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the payload array has no reset; a slot is only read after it has been
    // written, so clearing it would cost a reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

`ifndef SYNTHESIS
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("skid_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("skid_fifo: AFULL_TH must lie in 1..DEPTH");
    end

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && empty));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.valid_out && !bus.ready_in && !flush_i) |=> $stable(bus.data_out));
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (build with SKID_FIFO_BYPASS_EN to cover fall-through).
module tb_skid_fifo;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
`ifdef SKID_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic [2:0] count_o;
    logic       almost_full_o;

    skid_fifo_if #(.WIDTH(WIDTH)) bus ();

    skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .bus           (bus),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] mdl[$];
    logic [WIDTH-1:0] got[$];
    bit               model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue updated from the inputs seen at each edge.
    always @(posedge clk) begin
        int  n;
        bit  bypassed;
        if (!rst_n) begin
            mdl.delete();
            model_ok = 1'b1;
        end else if (flush_i) begin
            mdl.delete();
        end else begin
            n        = mdl.size();
            bypassed = BYP && n == 0 && bus.valid_in && bus.ready_in;
            if (!bypassed) begin
                if (n > 0 && bus.ready_in) void'(mdl.pop_front());
                if (bus.valid_in && n != DEPTH) mdl.push_back(bus.data_in);
            end
        end
    end

    // Compare process: mid-cycle, all inputs and outputs are settled.
    always @(negedge clk) begin
        bit               exp_valid;
        logic [WIDTH-1:0] exp_data;
        if (model_ok) begin
            exp_valid = (mdl.size() != 0) || (BYP && bus.valid_in && !flush_i);
            exp_data  = (mdl.size() != 0) ? mdl[0] : bus.data_in;
            check("cmp_valid_out", 32'(bus.valid_out), 32'(exp_valid));
            check("cmp_ready_out", 32'(bus.ready_out), 32'(mdl.size() != DEPTH));
            check("cmp_count",     32'(count_o),       32'(mdl.size()));
            check("cmp_afull",     32'(almost_full_o), 32'(mdl.size() >= AFULL_TH));
            if (exp_valid) check("cmp_data_out", bus.data_out, exp_data);
            if (rst_n && !flush_i && bus.valid_out && bus.ready_in) got.push_back(bus.data_out);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [WIDTH-1:0] base, input int n);
        bus.ready_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = base + WIDTH'(i);
            cyc();
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic drain_all();
        bus.ready_in = 1'b1;
        repeat (DEPTH + 2) cyc();
        bus.ready_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready_in = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset state.
        check("rst_count",     32'(count_o),       0);
        check("rst_valid_out", 32'(bus.valid_out), 0);
        check("rst_ready_out", 32'(bus.ready_out), 1);
        check("rst_afull",     32'(almost_full_o), 0);

        // Fill 0xA0..0xA3 with downstream stalled.
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 32'hA0 + 32'(i);
            cyc();
            check("fill_count", 32'(count_o),       32'(i + 1));
            check("fill_afull", 32'(almost_full_o), 32'(i + 1 >= 3));
            check("fill_ready", 32'(bus.ready_out), 32'(i < 3));
        end
        bus.valid_in = 1'b0;

        // Drain in order, one per cycle.
        bus.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(bus.valid_out), 1);
            check("drain_data",  bus.data_out,       32'hA0 + 32'(i));
            cyc();
        end
        check("drain_count", 32'(count_o),       0);
        check("drain_valid_end", 32'(bus.valid_out), 0);
        bus.ready_in = 1'b0;

        // Full with simultaneous pop: push blocked the first cycle.
        push_n(32'hC0, 4);
        check("fwp_ready_full", 32'(bus.ready_out), 0);
        bus.valid_in = 1'b1;
        bus.data_in  = 32'hB0;
        bus.ready_in = 1'b1;
        cyc();
        check("fwp_c1_count", 32'(count_o),   3);
        check("fwp_c1_head",  bus.data_out,   32'hC1);
        cyc();
        check("fwp_c2_count", 32'(count_o),   3);
        bus.valid_in = 1'b0;
        check("fwp_out0", bus.data_out, 32'hC2);
        cyc();
        check("fwp_out1", bus.data_out, 32'hC3);
        cyc();
        check("fwp_out2", bus.data_out, 32'hB0);
        cyc();
        check("fwp_empty", 32'(bus.valid_out), 0);
        bus.ready_in = 1'b0;

        // Wrap: 20 beats with ready_in toggling 1,0,1,0.
        got.delete();
        sent = 0;
        for (int c = 0; c < 200 && got.size() < 20; c++) begin
            bus.valid_in = (sent < 20);
            bus.data_in  = 32'(sent);
            bus.ready_in = (c % 2 == 0);
            if (bus.valid_in && bus.ready_out) sent++;
            cyc();
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        check("wrap_beats", 32'(got.size()), 20);
        for (int i = 0; i < 20; i++) check("wrap_order", got[i], 32'(i));

        // Flush at count 3 with a same-cycle input beat.
        cyc();
        got.delete();
        push_n(32'hD0, 3);
        check("flush_pre_count", 32'(count_o), 3);
        flush_i      = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 32'hFF;
        check("flush_ready_during", 32'(bus.ready_out), 1);
        cyc();
        flush_i      = 1'b0;
        bus.valid_in = 1'b0;
        check("flush_count", 32'(count_o),       0);
        check("flush_valid", 32'(bus.valid_out), 0);
        check("flush_ready", 32'(bus.ready_out), 1);
        push_n(32'h11, 1);
        drain_all();
        check("flush_after_beats", 32'(got.size()), 1);
        check("flush_after_data",  got[0],          32'h11);

        // Reset mid-stream at count 2.
        got.delete();
        push_n(32'hE0, 2);
        check("mrst_pre_count", 32'(count_o), 2);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mrst_valid", 32'(bus.valid_out), 0);
        check("mrst_ready", 32'(bus.ready_out), 1);
        check("mrst_count", 32'(count_o),       0);
        push_n(32'h55, 1);
        drain_all();
        check("mrst_after_beats", 32'(got.size()), 1);
        check("mrst_after_data",  got[0],          32'h55);

`ifdef SKID_FIFO_BYPASS_EN
        // Fall-through on an empty buffer.
        bus.valid_in = 1'b1;
        bus.data_in  = 32'h77;
        bus.ready_in = 1'b1;
        #1;
        check("byp_valid", 32'(bus.valid_out), 1);
        check("byp_data",  bus.data_out,       32'h77);
        check("byp_count", 32'(count_o),       0);
        cyc();
        check("byp_count_after", 32'(count_o), 0);
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
`endif

        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/skid_fifo.md
Name: skid_fifo

Overview:
- Parametrised N-entry elastic buffer for ready/valid pipeline decoupling between OoO front-end and back-end stages.
- Generalises the 1-entry skid stage to DEPTH entries with occupancy and almost-full reporting.
- ready_out is derived from registered state only, which breaks the combinational ready path across stages.
- Supports single-cycle flush for misprediction recovery.

Parameters:
- WIDTH, 32: payload width in bits.
- DEPTH, 4: number of entries; power of two, >= 2.
- AFULL_TH, 3: almost_full_o asserts when count_o >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- flush_i  input  1  drops all buffered entries and the input beat of the same cycle.
- valid_in  input  1  upstream beat valid.
- ready_out  output  1  buffer can accept a beat.
- data_in  input  WIDTH  upstream payload.
- valid_out  output  1  downstream beat valid.
- ready_in  input  1  downstream accepts the beat.
- data_out  output  WIDTH  payload at head of queue.
- count_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full_o  output  1  count_o >= AFULL_TH.

Behaviour:
- State:
  - Storage array mem[DEPTH].
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
  - count register, $clog2(DEPTH+1) bits.
- Handshake definitions:
  - push = valid_in && ready_out && !flush_i.
  - pop = valid_out && ready_in && !flush_i.
- ready_out = (count != DEPTH). It does not depend on ready_in.
  - When full, a same-cycle pop does NOT enable a push.
- valid_out = (count != 0).
- data_out = mem[rd_ptr]. Its value is don't-care when valid_out = 0.
- Latency: a beat pushed in cycle t is visible on valid_out/data_out in cycle t+1 at the earliest.
- Push: mem[wr_ptr] <= data_in; wr_ptr++.
- Pop: rd_ptr++.
- Count update:
  - count += 1 on push only.
  - count -= 1 on pop only.
  - Unchanged on simultaneous push and pop.
- Ordering is strict FIFO; data_out holds stable while valid_out && !ready_in.
- Flush:
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0.
  - The same-cycle valid_in beat is discarded and no pop is recorded.
  - mem contents are not cleared.
  - ready_out stays as computed from pre-flush count during the flush cycle.
- Reset (rst_n = 0 at a clock edge):
  - count = 0, pointers = 0, valid_out = 0, count_o = 0.
  - almost_full_o = 0 (AFULL_TH >= 1).
  - ready_out = 1.
  - Reset has priority over flush_i.
  - Reset mid-stream drops all entries, identical to flush.
- Boundaries:
  - Empty with push only: valid_out rises next cycle.
  - Full: ready_out = 0 until a pop retires, then rises the following cycle.
  - Pointer wrap from DEPTH-1 to 0 is transparent to ordering.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No pop while empty.
  - data_out stable while valid_out && !ready_in.

Optional Feature:
- Macro: SKID_FIFO_BYPASS_EN.
- Defined (fall-through mode):
  - When count == 0 and !flush_i, valid_out = valid_in and data_out = data_in combinationally; zero-cycle latency.
  - If ready_in is also high, the beat is consumed directly and is not written; count and pointers are unchanged.
  - If ready_in is low, the beat is written normally.
- Undefined: no input-to-output combinational path; minimum latency 1 cycle as above.

Test Plan:
- Fill and drain, DEPTH = 4, no bypass:
  - Push 0xA0..0xA3 with ready_in = 0 → count_o 1,2,3,4; almost_full_o rises at count 3; ready_out = 0 at count 4.
  - Then ready_in = 1 → outputs 0xA0,0xA1,0xA2,0xA3 in order, one per cycle, and count_o returns to 0.
- Full-with-pop: at count 4, hold valid_in = 1 (0xB0) and ready_in = 1.
  - Cycle 1: pop only; 0xB0 not accepted; count_o = 3.
  - Cycle 2: 0xB0 accepted with a pop; count_o stays 3.
- Wrap: stream 20 beats (0..19) with ready_in toggling 1,0,1,0 → output sequence exactly 0..19 with no loss or duplication; pointers wrap 5 times.
- Flush: count = 3, assert flush_i with valid_in = 1 (0xFF) → next cycle count_o = 0, valid_out = 0, ready_out = 1; 0xFF never appears at the output.
- Reset mid-operation: count = 2, drive rst_n = 0 for one edge → valid_out = 0, ready_out = 1, count_o = 0. A subsequent push of 0x55 appears alone at the output.
- Bypass (SKID_FIFO_BYPASS_EN defined): empty FIFO, valid_in = 1 (0x77), ready_in = 1 → same cycle valid_out = 1 and data_out = 0x77; count_o stays 0.
